// File: rtl/seven_seg_scan_driver_if.sv
// Bundle between the display value source and the seven-segment scan driver.
// master: value source / top level side; slave: the scan driver itself.
interface seven_seg_scan_driver_if;
  logic [15:0] value_in;
  logic        load;
  logic        disp_en;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_tick;
  logic        load_ack;

  modport master (
    output value_in, load, disp_en,
    input  digit_sel, nibble, blank, frame_tick, load_ack
  );

  modport slave (
    input  value_in, load, disp_en,
    output digit_sel, nibble, blank, frame_tick, load_ack
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit time-multiplexed scanner feeding the seven-segment decoder; loads land only at frame boundaries.
// Optional build macro SCAN_LZ_SUPPRESS_EN enables leading-zero blanking on digits 0..2.
module seven_seg_scan_driver #(
  parameter int PRESCALE = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  seven_seg_scan_driver_if.slave   bus
);
  localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_reg, pcnt_next;
  logic [1:0]    sel_reg, sel_next;
  logic [15:0]   shown_reg, shown_next;
  logic [15:0]   pending_reg, pending_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [3:0]    nibble_reg, nibble_next;
  logic          blank_reg, blank_next;
  logic          tick_reg, ack_reg;
  logic          tc, fb, apply;
  logic [3:0]    digit_arr [4];
  logic [3:0]    lz_mask;

  assign tc    = (pcnt_reg == PCNT_LAST);
  assign fb    = tc && (sel_reg == 2'd3);
  assign apply = fb && (bus.load || pend_valid_reg);

  always_comb begin
    pcnt_next       = tc ? '0 : pcnt_reg + PW'(1);
    sel_next        = tc ? sel_reg + 2'd1 : sel_reg;
    shown_next      = shown_reg;
    pending_next    = pending_reg;
    pend_valid_next = pend_valid_reg;
    if (fb) begin
      // A load landing on the boundary itself goes straight to the display.
      if (bus.load)
        shown_next = bus.value_in;
      else if (pend_valid_reg)
        shown_next = pending_reg;
      pend_valid_next = 1'b0;
    end else if (bus.load) begin
      pending_next    = bus.value_in;
      pend_valid_next = 1'b1;
    end
  end

  // Nibble and blank look ahead at the value/digit that become current on this edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_arr[gi] = shown_next[15-4*gi -: 4];
`ifdef SCAN_LZ_SUPPRESS_EN
      if (gi < 3) begin : g_lz
        assign lz_mask[gi] = ~|shown_next[15 -: 4*(gi+1)];
      end else begin : g_keep
        assign lz_mask[gi] = 1'b0;
      end
`else
      assign lz_mask[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    nibble_next = digit_arr[sel_next];
    blank_next  = ~bus.disp_en | lz_mask[sel_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg       <= '0;
      sel_reg        <= 2'd0;
      shown_reg      <= 16'h0000;
      pending_reg    <= 16'h0000;
      pend_valid_reg <= 1'b0;
      nibble_reg     <= 4'h0;
      blank_reg      <= 1'b1;
      tick_reg       <= 1'b0;
      ack_reg        <= 1'b0;
    end else begin
      pcnt_reg       <= pcnt_next;
      sel_reg        <= sel_next;
      shown_reg      <= shown_next;
      pending_reg    <= pending_next;
      pend_valid_reg <= pend_valid_next;
      nibble_reg     <= nibble_next;
      blank_reg      <= blank_next;
      tick_reg       <= fb;
      ack_reg        <= apply;
    end
  end

  assign bus.digit_sel  = sel_reg;
  assign bus.nibble     = nibble_reg;
  assign bus.blank      = blank_reg;
  assign bus.frame_tick = tick_reg;
  assign bus.load_ack   = ack_reg;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for the scan driver against a cycle-count based reference model.
// Expected outputs are derived from edge count since reset, frame arithmetic and a pending-load record.
module tb_seven_seg_scan_driver;
  localparam int P     = 4;
  localparam int FRAME = 4 * P;

  logic clk = 1'b0;
  logic rst;
  seven_seg_scan_driver_if bus ();

  seven_seg_scan_driver #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          t        = 0;
  logic [15:0] m_shown  = 16'h0000;
  logic [15:0] m_pend   = 16'h0000;
  logic        m_pv     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".digit_sel"}, 32'(bus.digit_sel), 32'd0);
    check({tag, ".nibble"},    32'(bus.nibble),    32'd0);
    check({tag, ".blank"},     32'(bus.blank),     32'd1);
    check({tag, ".tick"},      32'(bus.frame_tick), 32'd0);
    check({tag, ".ack"},       32'(bus.load_ack),  32'd0);
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic       fb;
    logic       exp_ack;
    int         exp_sel;
    logic [3:0] exp_nib;
    logic       exp_blank;
    @(posedge clk);
    t++;
    fb      = (t % FRAME == 0);
    exp_ack = 1'b0;
    if (fb) begin
      if (bus.load) begin
        m_shown = bus.value_in;
        exp_ack = 1'b1;
      end else if (m_pv) begin
        m_shown = m_pend;
        exp_ack = 1'b1;
      end
      m_pv = 1'b0;
    end else if (bus.load) begin
      m_pend = bus.value_in;
      m_pv   = 1'b1;
    end
    exp_sel   = (t / P) % 4;
    exp_nib   = 4'((m_shown >> (4 * (3 - exp_sel))) & 16'h000F);
    exp_blank = !bus.disp_en;
`ifdef SCAN_LZ_SUPPRESS_EN
    if (exp_sel < 3 && (m_shown >> (4 * (3 - exp_sel))) == 16'h0000)
      exp_blank = 1'b1;
`endif
    #1;
    check("digit_sel",  32'(bus.digit_sel),  32'(exp_sel));
    check("nibble",     32'(bus.nibble),     32'(exp_nib));
    check("blank",      32'(bus.blank),      32'(exp_blank));
    check("frame_tick", 32'(bus.frame_tick), 32'(fb));
    check("load_ack",   32'(bus.load_ack),   32'(exp_ack));
    if (exp_ack)
      $display("load_ack t=%0d shown=%04h", t, m_shown);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.value_in = v;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic model_reset();
    t       = 0;
    m_shown = 16'h0000;
    m_pend  = 16'h0000;
    m_pv    = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value_in = 16'h0000;
    bus.disp_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Idle scan with all-zero value
    run(2 * FRAME + 8);

    // Single mid-frame load
    while (t % FRAME != 6) step();
    pulse_load(16'h1A2F);
    run(2 * FRAME);

    // Two loads in one frame: last wins, one ack
    while (t % FRAME != 2) step();
    pulse_load(16'h1111);
    step();
    pulse_load(16'h2222);
    run(FRAME + 4);

    // Load exactly on the frame-boundary edge
    while ((t + 1) % FRAME != 0) step();
    pulse_load(16'h3333);
    run(FRAME + 4);

    // Leading-zero patterns
    pulse_load(16'h00A0);
    run(2 * FRAME);
    pulse_load(16'h0000);
    run(2 * FRAME);

    // disp_en toggling off-phase with the digit terminal count
    while (t % P != 1) step();
    bus.disp_en = 1'b0;
    run(3);
    bus.disp_en = 1'b1;
    run(5);
    bus.disp_en = 1'b0;
    run(1);
    bus.disp_en = 1'b1;
    run(FRAME);

    // Randomized loads and display enables
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.value_in = 16'($urandom);
        bus.load     = 1'b1;
      end else begin
        bus.load     = 1'b0;
      end
      if ($urandom_range(0, 9) == 0)
        bus.disp_en = ~bus.disp_en;
      step();
    end
    bus.load    = 1'b0;
    bus.disp_en = 1'b1;
    run(FRAME);

    // Asynchronous reset mid-frame with a load pending
    while (t % FRAME != 5) step();
    pulse_load(16'hBEEF);
    run(2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(2 * FRAME + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexing scanner that sits directly upstream of the seven-segment decoder on the Basys3 display path. It holds a 16-bit value as four hex digits, steps a 2-bit digit select through all four digits at a programmable rate, and presents the selected 4-bit nibble plus digit select to the decoder's `X` and `sw` inputs. New values are accepted through a load strobe and applied only at frame boundaries, so a digit never shows a torn frame. A blank output lets the top level gate the anodes.

## Interface
- `PRESCALE`, 100000, clk cycles each digit is held; 1 ms/digit at 100 MHz; minimum legal value 2
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `value_in`  input  16  value to display; [15:12] leftmost digit, [3:0] rightmost
- `load`  input  1  single-cycle strobe; captures `value_in` into the pending register
- `disp_en`  input  1  1 = display on, 0 = force `blank`
- `digit_sel`  output  2  drives decoder `sw`; 0 = leftmost digit (AN3) … 3 = rightmost (AN0)
- `nibble`  output  4  drives decoder `X`; digit of shown value selected by `digit_sel`
- `blank`  output  1  1 = current digit must be dark (top level forces anodes to 4'b1111)
- `frame_tick`  output  1  one-cycle pulse on first cycle of each new frame
- `load_ack`  output  1  one-cycle pulse when a pending value becomes the shown value

## Operation
- Registers: prescale counter `pcnt` ($clog2(PRESCALE) bits), `digit_sel`, `shown[15:0]`, `pending[15:0]`, `pend_valid`.
- `pcnt` counts 0..PRESCALE-1, wraps to 0. Terminal cycle (TC) = `pcnt == PRESCALE-1`.
- On TC: `digit_sel` increments mod 4 (3 → 0 wraps).
- Frame boundary (FB) = TC with `digit_sel == 3`. On FB: if `pend_valid` (or `load` high that same cycle), `shown` ← pending value, `pend_valid` ← 0, `load_ack` = 1 next cycle; `frame_tick` = 1 next cycle regardless.
- `load` high on non-FB cycle: `pending` ← `value_in`, `pend_valid` ← 1. Repeated loads before FB: last wins; only one `load_ack` per FB.
- `load` high on an FB cycle: `value_in` bypasses `pending` and is applied at that FB.
- `nibble` = `shown[15-4*digit_sel -: 4]` for the next `digit_sel`, registered so `nibble` and `digit_sel` change on the same edge.
- `blank` = `~disp_en` (registered), OR leading-zero rule when configured.
- Reset values: `pcnt`=0, `digit_sel`=0, `nibble`=0, `shown`=0, `pending`=0, `pend_valid`=0, `blank`=1, `frame_tick`=0, `load_ack`=0. Reset mid-frame discards pending load; scan restarts at digit 0.

## Timing
- Each digit held exactly PRESCALE cycles; frame = 4·PRESCALE cycles.
- `digit_sel`, `nibble`, `blank` update on the edge after TC; all outputs registered, no combinational input→output paths.
- Load-to-display latency: from `load` to `load_ack` ≤ 4·PRESCALE cycles; `load_ack` coincides with `frame_tick` and with `digit_sel`=0 showing the new [15:12].
- `disp_en` change reaches `blank` one cycle later, independent of TC.
- After reset release: first `frame_tick` at cycle 4·PRESCALE (counting the first post-reset edge as cycle 1).

## Configuration
- `SCAN_LZ_SUPPRESS_EN` defined: leading-zero suppression. For digits 0..2, `blank`=1 if that digit and all digits to its left in `shown` are 0. Digit 3 is never suppressed (value 0 shows a single "0"). Still OR'd with `~disp_en`.
- Undefined: `blank` = `~disp_en` only; all four digits always lit, zeros shown.

## Test plan
- Reset, PRESCALE=4, `disp_en`=1, no load → `digit_sel` sequence 0,1,2,3,0 each held 4 cycles, `nibble`=0, `frame_tick` every 16 cycles, `load_ack` never.
- `value_in`=16'h1A2F, `load` pulse mid-frame → `load_ack`+`frame_tick` together at next FB; then `nibble` = 1,A,2,F for `digit_sel` 0..3.
- Loads 16'h1111 then 16'h2222 within one frame → single `load_ack`, shown = 16'h2222; `load` exactly on FB cycle with 16'h3333 → applied at that FB.
- `disp_en` toggled 1→0→1 → `blank` follows one cycle later, scan counters unaffected.
- Assert `rst` mid-frame with pending load → all outputs to reset values, no `load_ack` after release, shown = 0.
- With `SCAN_LZ_SUPPRESS_EN`, shown 16'h00A0 → `blank`=1 for digit_sel 0,1, 0 for 2,3; shown 16'h0000 → blank only on digits 0..2.
